// File: rtl/ascii_dec_parser.sv
//------------------------------------------------------------------------------
// Module   : ascii_dec_parser
// Brief    : Streams ASCII decimal text (optional '-', digits, CR/LF) into a
//            two's-complement value. Sign support selected by ASCII_PARSER_SIGN_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ascii_dec_parser #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             error,
    output logic             busy
);

    localparam int C_AW  = WIDTH + 4;
    localparam int C_NDW = $clog2(MAX_DIGITS + 2);
    localparam logic [C_NDW-1:0] C_MAXD = C_NDW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIGITS  = 2'd1,
        S_OUT     = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [C_AW-1:0]    r_acc, w_acc_next;
    logic [C_NDW-1:0]   r_ndig, w_ndig_next;
    logic               r_neg, w_neg_next;
    logic               r_seen, w_seen_next;
    logic [WIDTH-1:0]   r_value;
    logic               r_error, w_error_next;
    logic               w_load_value;

    logic               w_fire;
    logic               w_is_digit;
    logic               w_is_term;
    logic [C_AW-1:0]    w_digit;
    logic [C_AW-1:0]    w_acc_mac;
    logic [C_NDW-1:0]   w_ndig_inc;
    logic [C_AW-1:0]    w_limit;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_acc_lo;

    assign w_fire     = char_valid && char_ready;
    assign w_is_digit = (char_data >= 8'h30) && (char_data <= 8'h39);
    assign w_is_term  = (char_data == 8'h0D) || (char_data == 8'h0A);
    assign w_digit    = {{WIDTH{1'b0}}, char_data[3:0]};
    assign w_acc_mac  = (r_acc << 3) + (r_acc << 1) + w_digit;
    // Leading zeros leave the accumulator at zero, so they do not bump ndig.
    assign w_ndig_inc = r_ndig + C_NDW'(w_acc_mac != '0);
    assign w_acc_lo   = r_acc[WIDTH-1:0];

`ifdef ASCII_PARSER_SIGN_EN
    localparam logic [C_AW-1:0] C_POS_LIM = {5'b0, {(WIDTH-1){1'b1}}};
    localparam logic [C_AW-1:0] C_NEG_LIM = {4'b0, 1'b1, {(WIDTH-1){1'b0}}};
    assign w_limit = r_neg ? C_NEG_LIM : C_POS_LIM;
`else
    localparam logic [C_AW-1:0] C_UNS_LIM = {4'b0, {WIDTH{1'b1}}};
    assign w_limit = C_UNS_LIM;
`endif

    assign w_ovf = (w_acc_mac > w_limit) || (w_ndig_inc > C_MAXD);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_ndig_next  = r_ndig;
        w_neg_next   = r_neg;
        w_seen_next  = r_seen;
        w_error_next = 1'b0;
        w_load_value = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (w_is_digit) begin
                        w_acc_next   = w_digit;
                        w_ndig_next  = C_NDW'(char_data[3:0] != 4'd0);
                        w_seen_next  = 1'b1;
                        w_state_next = S_DIGITS;
`ifdef ASCII_PARSER_SIGN_EN
                    end else if (char_data == 8'h2D) begin
                        w_neg_next   = 1'b1;
                        w_state_next = S_DIGITS;
`endif
                    end else if (!(w_is_term || char_data == 8'h20)) begin
                        w_state_next = S_DISCARD;
                    end
                end
            end
            S_DIGITS: begin
                if (w_fire) begin
                    if (w_is_digit) begin
                        if (w_ovf) begin
                            w_state_next = S_DISCARD;
                        end else begin
                            w_acc_next  = w_acc_mac;
                            w_ndig_next = w_ndig_inc;
                            w_seen_next = 1'b1;
                        end
                    end else if (w_is_term) begin
                        if (r_seen) begin
                            w_load_value = 1'b1;
                            w_state_next = S_OUT;
                        end else begin
                            w_error_next = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_state_next = S_DISCARD;
                    end
                end
            end
            S_OUT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                if (w_fire && w_is_term) begin
                    w_error_next = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
        endcase
        if (w_state_next == S_IDLE) begin
            w_acc_next  = '0;
            w_ndig_next = '0;
            w_neg_next  = 1'b0;
            w_seen_next = 1'b0;
        end
    end

    // value is captured on the terminator edge so it is stable throughout OUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ndig  <= '0;
            r_neg   <= 1'b0;
            r_seen  <= 1'b0;
            r_value <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_ndig  <= w_ndig_next;
            r_neg   <= w_neg_next;
            r_seen  <= w_seen_next;
            r_error <= w_error_next;
            if (w_load_value) begin
                r_value <= r_neg ? -w_acc_lo : w_acc_lo;
            end
        end
    end

    assign value       = r_value;
    assign error       = r_error;
    assign value_valid = (r_state == S_OUT);
    assign char_ready  = (r_state != S_OUT);
    assign busy        = (r_state == S_DIGITS) || (r_state == S_DISCARD);

endmodule

`default_nettype wire

// File: tb/tb_ascii_dec_parser.sv
//------------------------------------------------------------------------------
// Module   : tb_ascii_dec_parser
// Brief    : Directed self-checking bench for ascii_dec_parser.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ascii_dec_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [31:0] value;
    logic        value_valid;
    logic        error;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int err_cnt = 0;
    int vv_cnt  = 0;
    int ready_bad = 0;
    int err_snap;
    int vv_snap;
    logic [31:0] vv_q[$];

    ascii_dec_parser #(.WIDTH(32), .MAX_DIGITS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .value      (value),
        .value_valid(value_valid),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (value_valid) begin
                vv_q.push_back(value);
                vv_cnt++;
                if (char_ready) ready_bad++;
            end
            if (error) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Holds the character until the handshake edge; returns 1ns after it.
    task automatic send_char(input byte c);
        logic acc_ok;
        int   n;
        char_valid = 1'b1;
        char_data  = c;
        n = 0;
        forever begin
            acc_ok = char_ready;
            @(posedge clk);
            #1;
            if (acc_ok) break;
            n++;
            if (n > 50) begin
                chk("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        char_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 32'd0);
        chk("rst_vv", {31'd0, value_valid}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, char_ready}, 32'd1);
        reset = 1'b0;
        tick();

        send_line("1234\r");
        chk("1234_vv", {31'd0, value_valid}, 32'd1);
        chk("1234_val", value, 32'd1234);
        chk("1234_ready", {31'd0, char_ready}, 32'd0);
        tick();
        chk("1234_vv_drop", {31'd0, value_valid}, 32'd0);
        chk("1234_hold", value, 32'd1234);

        send_line("00000000000012\r");
        chk("lz_val", value, 32'd12);
        tick();

`ifdef ASCII_PARSER_SIGN_EN
        send_line("  -0042\n");
        chk("neg42_val", value, 32'hFFFF_FFD6);
        chk("neg42_err", {31'd0, error}, 32'd0);
        tick();
        send_line("2147483648\r");
        chk("posovf_err", {31'd0, error}, 32'd1);
        chk("posovf_hold", value, 32'hFFFF_FFD6);
        tick();
        send_line("-2147483648\r");
        chk("negmax_val", value, 32'h8000_0000);
        tick();
`else
        send_line("-5\r");
        chk("minus_err", {31'd0, error}, 32'd1);
        chk("minus_hold", value, 32'd12);
        tick();
        send_line("4294967295\r");
        chk("umax_val", value, 32'hFFFF_FFFF);
        tick();
        send_line("4294967296\r");
        chk("uovf_err", {31'd0, error}, 32'd1);
        chk("uovf_hold", value, 32'hFFFF_FFFF);
        tick();
`endif

        err_snap = err_cnt;
        vv_snap  = vv_cnt;
        send_line("12a3");
        chk("bad_busy", {31'd0, busy}, 32'd1);
        send_line("\r");
        chk("bad_err", {31'd0, error}, 32'd1);
        chk("bad_vv", {31'd0, value_valid}, 32'd0);
        tick();
        chk("bad_err_drop", {31'd0, error}, 32'd0);
        chk("bad_err_count", err_cnt - err_snap, 32'd1);
        chk("bad_no_vv", vv_cnt - vv_snap, 32'd0);
        send_line("7\r");
        chk("seven_val", value, 32'd7);
        tick();

        err_snap = err_cnt;
        send_line("98");
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_value", value, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send_line("5\r");
        chk("after_rst_val", value, 32'd5);
        tick();
        chk("after_rst_noerr", err_cnt - err_snap, 32'd0);

        vv_q.delete();
        ready_bad = 0;
        send_char(8'h31);
        send_char(8'h0D);
        send_char(8'h32);
        send_char(8'h0D);
        char_valid = 1'b0;
        tick();
        tick();
        chk("b2b_count", vv_q.size(), 32'd2);
        chk("b2b_first", vv_q[0], 32'd1);
        chk("b2b_second", vv_q[1], 32'd2);
        chk("b2b_ready_low", ready_bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
